// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Sequential binary-to-BCD converter for the calculator display path. It
// captures an ALU result on a start strobe and converts it with a double-dabble
// (shift-and-add-3) loop, one binary bit per clock. When sign_mode is set the
// operand is treated as two's complement and shown as sign plus magnitude.
// The BCD result and sign are held stable for the display driver until the
// next conversion completes.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      conversion request, sampled on the rising edge of clk
//   bin_in     WIDTH-bit value to convert (normally the ALU result)
//   sign_mode  1 = interpret bin_in as two's complement (sampled with start)
//   busy       high while the shift-and-add loop is running
//   done       one-cycle pulse: bcd/neg have just been updated
//   bcd        packed BCD result, digit 0 (ones) in [3:0]
//   neg        result sign, 1 = negative
//
// Timing
//   A start accepted at edge E0 runs the loop on edges E1..E16; the last
//   iteration also publishes the result, so done is high for the cycle after
//   E16. A start presented during that DONE cycle is accepted immediately,
//   giving one conversion every WIDTH+1 cycles. Starts during CONV are dropped.
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  sign_mode,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t            state_reg,   state_next;
  logic [CW-1:0]     cnt_reg,     cnt_next;
  logic [BW-1:0]     scratch_reg, scratch_next;
  logic [WIDTH-1:0]  mag_reg,     mag_next;
  logic              sign_reg,    sign_next;
  logic [BW-1:0]     bcd_reg,     bcd_next;
  logic              neg_reg,     neg_next;

  // ---------------------------------------------------------------------------
  // Operand preparation for a new conversion. The magnitude is kept WIDTH bits
  // unsigned: negating the most negative value (e.g. 0x8000) yields the same
  // bit pattern, which read as unsigned is exactly the right magnitude.
  // Zero never has its MSB set, so a negative zero cannot be produced.
  // ---------------------------------------------------------------------------
  logic              load_sign;
  logic [WIDTH-1:0]  load_mag;

  assign load_sign = sign_mode & bin_in[WIDTH-1];
  assign load_mag  = load_sign ? ((~bin_in) + WIDTH'(1)) : bin_in;

  // A start is honoured from IDLE and also from DONE (back-to-back), never
  // while a conversion is running.
  logic accept;
  assign accept = start & ((state_reg == IDLE) | (state_reg == DONE));

  // ---------------------------------------------------------------------------
  // One double-dabble iteration: correct every BCD digit that would overflow
  // past 9 after doubling (>= 5 -> +3), then shift {scratch, magnitude} left.
  // ---------------------------------------------------------------------------
  logic [BW-1:0]     scratch_adj;
  logic [BW-1:0]     scratch_shift;
  logic [WIDTH-1:0]  mag_shift;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
      logic [3:0] digit;
      assign digit = scratch_reg[4*gi +: 4];
      assign scratch_adj[4*gi +: 4] = (digit >= 4'd5) ? (digit + 4'd3) : digit;
    end
  endgenerate

  generate
    if (WIDTH > 1) begin : g_mag_shift_wide
      assign mag_shift = {mag_reg[WIDTH-2:0], 1'b0};
    end else begin : g_mag_shift_narrow
      assign mag_shift = '0;
    end
  endgenerate

  assign scratch_shift = {scratch_adj[BW-2:0], mag_reg[WIDTH-1]};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      scratch_reg <= '0;
      mag_reg     <= '0;
      sign_reg    <= 1'b0;
      bcd_reg     <= '0;
      neg_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      scratch_reg <= scratch_next;
      mag_reg     <= mag_next;
      sign_reg    <= sign_next;
      bcd_reg     <= bcd_next;
      neg_reg     <= neg_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    scratch_next = scratch_reg;
    mag_next     = mag_reg;
    sign_next    = sign_reg;
    bcd_next     = bcd_reg;
    neg_next     = neg_reg;

    case (state_reg)
      IDLE: begin
        state_next = IDLE;
      end

      CONV: begin
        scratch_next = scratch_shift;
        mag_next     = mag_shift;
        cnt_next     = cnt_reg + CW'(1);
        // The final iteration publishes its own shifted result directly so
        // the display value lands on the same edge that ends the loop.
        if (cnt_reg == LAST_ITER) begin
          bcd_next   = scratch_shift;
          neg_next   = sign_reg;
          cnt_next   = '0;
          state_next = DONE;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Loading a new operand overrides the idle/done transition; bcd/neg are
    // untouched so the display keeps the previous result during conversion.
    if (accept) begin
      sign_next    = load_sign;
      mag_next     = load_mag;
      scratch_next = '0;
      cnt_next     = '0;
      state_next   = CONV;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from registers only.
  // ---------------------------------------------------------------------------
  assign busy = (state_reg == CONV);
  assign done = (state_reg == DONE);
  assign bcd  = bcd_reg;
  assign neg  = neg_reg;

endmodule
